// File: rtl/grey_codec.sv
// rtl/grey_codec.sv - Grey/natural binary converter with a grey-coded up/down counter
module grey_codec #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             valid_in,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] count_nat,
    output logic [WIDTH-1:0] count_grey,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] to_grey(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    logic [WIDTH-1:0] din_nat;
    logic [WIDTH-1:0] count_step;
    logic             step_wraps;
    logic             acc;

    // Grey-to-natural: each bit is the XOR of all din bits at or above it.
    always_comb begin
        din_nat = '0;
        acc     = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc        = acc ^ din[i];
            din_nat[i] = acc;
        end
    end

    always_comb begin
        count_step = '0;
        step_wraps = 1'b0;
        if (mode[0]) begin
            count_step = count_nat - ONE;
            step_wraps = (count_nat == '0);
        end else begin
            count_step = count_nat + ONE;
            step_wraps = (count_nat == ONES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            count_nat  <= '0;
            count_grey <= '0;
            wrap       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
            if (!mode[1]) begin
                if (valid_in) begin
                    dout       <= mode[0] ? din_nat : to_grey(din);
                    dout_valid <= 1'b1;
                end
            end else if (load) begin
                count_nat  <= din;
                count_grey <= to_grey(din);
                dout       <= to_grey(din);
                dout_valid <= 1'b1;
            end else if (en) begin
                count_nat  <= count_step;
                count_grey <= to_grey(count_step);
                dout       <= to_grey(count_step);
                dout_valid <= 1'b1;
                wrap       <= step_wraps;
            end
        end
    end

endmodule

// File: tb/tb_grey_codec.sv
// tb/tb_grey_codec.sv - Directed self-checking bench for grey_codec
module tb_grey_codec;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mode;
    logic         valid_in;
    logic         en;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic [W-1:0] count_nat;
    logic [W-1:0] count_grey;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] grey_tbl [0:16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
        4'b0000
    };

    grey_codec #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .valid_in   (valid_in),
        .en         (en),
        .load       (load),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count_nat  (count_nat),
        .count_grey (count_grey),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'b10; valid_in = 1'b1; en = 1'b1; load = 1'b1; din = 4'b1011;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({dout, dout_valid, count_nat, count_grey, wrap} !== 14'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b, want all zero", c,
                         {dout, dout_valid, count_nat, count_grey, wrap});
            end
        end
        rst_n = 1'b1; mode = 2'b00; valid_in = 1'b0; en = 1'b0; load = 1'b0;
        step();
        checks++;
        if (count_nat !== 4'd0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: count_nat=%b dout_valid=%b, want 0000/0", count_nat, dout_valid);
        end
    endtask

    task automatic test_nat2grey();
        mode = 2'b00; din = 4'b1011; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        checks++;
        if (dout !== 4'b1110 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL nat2grey: dout=%b valid=%b, want 1110/1", dout, dout_valid);
        end
        en = 1'b1; load = 1'b1; din = 4'b0101;
        step();
        checks++;
        if (dout !== 4'b1110 || dout_valid !== 1'b0 || count_nat !== 4'd0) begin
            errors++;
            $display("FAIL nat2grey_hold: dout=%b valid=%b count=%b, want 1110/0/0000",
                     dout, dout_valid, count_nat);
        end
        en = 1'b0; load = 1'b0;
    endtask

    task automatic test_grey2nat();
        mode = 2'b01; din = 4'b1110; valid_in = 1'b1;
        step();
        checks++;
        if (dout !== 4'b1011 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL grey2nat_1110: dout=%b valid=%b, want 1011/1", dout, dout_valid);
        end
        din = 4'b1000;
        step();
        valid_in = 1'b0;
        checks++;
        if (dout !== 4'b1111 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL grey2nat_1000: dout=%b valid=%b, want 1111/1", dout, dout_valid);
        end
    endtask

    task automatic test_count_up();
        logic [W-1:0] prev;
        logic [W-1:0] exp_nat;
        logic         exp_wrap;
        mode = 2'b10; en = 1'b1; valid_in = 1'b1;
        prev = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_nat  = W'(k % 16);
            exp_wrap = (k == 16);
            checks++;
            if (count_grey !== grey_tbl[k] || count_nat !== exp_nat || dout !== grey_tbl[k]
                || dout_valid !== 1'b1 || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL count_up step %0d: nat=%b grey=%b dout=%b valid=%b wrap=%b, want %b/%b/%b/1/%b",
                         k, count_nat, count_grey, dout, dout_valid, wrap,
                         exp_nat, grey_tbl[k], grey_tbl[k], exp_wrap);
            end
            checks++;
            if ($countones(prev ^ count_grey) != 1) begin
                errors++;
                $display("FAIL count_up_onebit step %0d: %b -> %b, want one bit change", k, prev, count_grey);
            end
            prev = count_grey;
        end
        en = 1'b0; valid_in = 1'b0;
        step();
        checks++;
        if (count_nat !== 4'd0 || dout_valid !== 1'b0 || wrap !== 1'b0 || dout !== 4'b0000) begin
            errors++;
            $display("FAIL count_hold: nat=%b valid=%b wrap=%b dout=%b, want 0000/0/0/0000",
                     count_nat, dout_valid, wrap, dout);
        end
    endtask

    task automatic test_load_down();
        mode = 2'b11; din = 4'b0000; load = 1'b1; en = 1'b1;
        step();
        checks++;
        if (count_nat !== 4'd0 || wrap !== 1'b0 || dout_valid !== 1'b1 || dout !== 4'b0000) begin
            errors++;
            $display("FAIL load_wins: nat=%b wrap=%b valid=%b dout=%b, want 0000/0/1/0000",
                     count_nat, wrap, dout_valid, dout);
        end
        load = 1'b0;
        step();
        en = 1'b0;
        checks++;
        if (count_nat !== 4'd15 || count_grey !== 4'b1000 || wrap !== 1'b1
            || dout !== 4'b1000 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: nat=%b grey=%b wrap=%b dout=%b valid=%b, want 1111/1000/1/1000/1",
                     count_nat, count_grey, wrap, dout, dout_valid);
        end
        step();
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse: wrap=%b, want 0", wrap);
        end
    endtask

    task automatic test_direction();
        logic [W-1:0] exp_seq [0:2] = '{4'd6, 4'd5, 4'd4};
        logic [W-1:0] exp_grey [0:2] = '{4'b0101, 4'b0111, 4'b0110};
        mode = 2'b10; din = 4'd5; load = 1'b1;
        step();
        load = 1'b0; en = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            mode = 2'b11;
            checks++;
            if (count_nat !== exp_seq[s] || count_grey !== exp_grey[s]) begin
                errors++;
                $display("FAIL direction step %0d: nat=%b grey=%b, want %b/%b",
                         s, count_nat, count_grey, exp_seq[s], exp_grey[s]);
            end
        end
        mode = 2'b00; valid_in = 1'b0;
        step();
        step();
        checks++;
        if (count_nat !== 4'd4 || dout !== 4'b0110 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL direction_hold: nat=%b dout=%b valid=%b, want 0100/0110/0",
                     count_nat, dout, dout_valid);
        end
        mode = 2'b10; rst_n = 1'b0;
        step();
        checks++;
        if ({dout, dout_valid, count_nat, count_grey, wrap} !== 14'd0) begin
            errors++;
            $display("FAIL midcount_reset: got %b, want all zero",
                     {dout, dout_valid, count_nat, count_grey, wrap});
        end
        rst_n = 1'b1;
        step();
        en = 1'b0;
        checks++;
        if (count_nat !== 4'd1 || count_grey !== 4'b0001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_step: nat=%b grey=%b wrap=%b, want 0001/0001/0",
                     count_nat, count_grey, wrap);
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; valid_in = 1'b0; en = 1'b0; load = 1'b0; din = '0;
        @(negedge clk);
        test_reset();
        test_nat2grey();
        test_grey2nat();
        test_count_up();
        test_load_down();
        test_direction();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grey_codec.md
GREY_CODEC -- requirements
Module: grey_codec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data/count width, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; synchronous and active-low, sampled on rising clk.
REQ-004 The block SHALL have port mode, input, 2, operation select: 00 nature->grey, 01 grey->nature, 10 grey count up, 11 grey count down.
REQ-005 The block SHALL have port valid_in, input, 1, din qualifier in conversion modes (00/01).
REQ-006 The block SHALL have port en, input, 1, count enable in counter modes (10/11).
REQ-007 The block SHALL have port load, input, 1, counter preload strobe in counter modes.
REQ-008 The block SHALL have port din, input, WIDTH, conversion operand or counter preload value (natural binary).
REQ-009 The block SHALL have port dout, output, WIDTH, registered result.
REQ-010 The block SHALL have port dout_valid, output, 1, one-cycle strobe marking a new dout.
REQ-011 The block SHALL have port count_nat, output, WIDTH, registered counter value in natural binary.
REQ-012 The block SHALL have port count_grey, output, WIDTH, registered counter value in grey code.
REQ-013 The block SHALL have port wrap, output, 1, one-cycle strobe on counter wrap-around.

Function
REQ-014 All outputs SHALL be registered; no combinational input-to-output path.
REQ-015 Mode 00, valid_in=1: the next cycle SHALL give dout = din ^ (din >> 1) and dout_valid=1.
REQ-016 Mode 01, valid_in=1: the next cycle SHALL give dout[i] = XOR of din[WIDTH-1:i] for every i, and dout_valid=1.
REQ-017 Conversion modes, valid_in=0: dout SHALL hold and dout_valid SHALL be 0; en and load are ignored and the counter holds.
REQ-018 Counter modes: valid_in SHALL be ignored.
REQ-019 Counter modes, load=1: the counter SHALL take count_nat <= din and count_grey <= grey(din), regardless of en; wrap=0.
REQ-020 Counter modes, load=0 and en=1: count_nat SHALL step by +1 in mode 10 and -1 in mode 11, modulo 2^WIDTH; count_grey SHALL equal grey(count_nat) in the same cycle.
REQ-021 Counter modes, load=0 and en=0: the counter SHALL hold and wrap SHALL be 0.
REQ-022 wrap SHALL be 1 for exactly the cycle after an up-step from all-ones to 0 or a down-step from 0 to all-ones; otherwise 0.
REQ-023 Counter modes: on every load or enabled step, the next cycle SHALL give dout = new count_grey and dout_valid=1; otherwise dout_valid=0 and dout holds.
REQ-024 Successive count_grey values from enabled steps SHALL differ in exactly one bit, including across wrap.
REQ-025 A mode change SHALL take effect on the same edge; the counter value SHALL persist across conversion modes; dout SHALL hold until the next qualified event.
REQ-026 A change between modes 10 and 11 SHALL reverse direction from the current value without skipping or repeating a code.

Reset
REQ-027 rst_n=0 at a rising edge SHALL clear dout, dout_valid, count_nat, count_grey and wrap to 0, overriding all other inputs.
REQ-028 Reset asserted mid-count or mid-conversion SHALL discard the pending operation; the first cycle after release SHALL behave as from the all-zero state.

Verification (WIDTH=4)
REQ-029 Reset: rst_n=0 for 2 cycles with valid_in=1, en=1, load=1 -> all outputs 0 throughout, count_nat=0 after release.
REQ-030 Mode 00, din=4'b1011, valid_in pulsed for 1 cycle -> next cycle dout=4'b1110, dout_valid=1; following cycle dout_valid=0, dout=4'b1110 held.
REQ-031 Mode 01, din=4'b1110, valid_in=1 -> dout=4'b1011; also din=4'b1000 -> dout=4'b1111.
REQ-032 Mode 10 from reset, en=1 for 16 cycles -> count_grey 0000,0001,0011,0010,0110,...,1000,0000; every transition changes exactly one bit; wrap=1 only on 1000->0000.
REQ-033 Mode 11, load=1 and en=1 together with din=0 -> count_nat=0 (load wins); then en=1 -> count_nat=15, count_grey=4'b1000, wrap=1, dout=4'b1000, dout_valid=1.
REQ-034 Mode 10 at count_nat=5, switch to mode 11 for 2 enabled steps then to mode 00 -> count_nat 6,5,4 then holds at 4; rst_n=0 at an arbitrary cycle of the sequence -> all outputs 0 on the next edge.
